alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 Port: req0_op  input  4  requester 0 ALUop; ADD=4'b0000, SUB=4'b0010.
REQ-008 Ports: req1_valid, req1_ready, req1_a, req1_b, req1_op: same as REQ-004..007, requester 1.
REQ-009 Port: rsp_valid  output  1  rsp_result/rsp_id hold a completed operation.
REQ-010 Port: rsp_ready  input  1  consumer accepts the response.
REQ-011 Port: rsp_result  output  WIDTH  registered arithmetic result.
REQ-012 Port: rsp_id  output  1  index of the requester that issued the operation.

Function
REQ-013 Block SHALL share one internal add/sub datapath between two requesters; op bit 1 selects the operation: 0 -> a+b, 1 -> a+~b+1 (two's-complement subtract); other op bits ignored.
REQ-014 Arithmetic SHALL be modulo 2^WIDTH; carry-out is discarded from rsp_result.
REQ-015 FSM states: IDLE, EXEC, RESP; exactly one operation in flight.
REQ-016 IDLE: if any reqN_valid, grant one, assert its reqN_ready combinationally for that cycle only, latch a/b/op/id, go to EXEC; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: priority pointer starts at requester 0 and, after each grant, points to the non-granted requester; single requester is always granted.
REQ-018 Both reqN_ready SHALL be 0 in EXEC and RESP; at most one reqN_ready high in any cycle.
REQ-019 EXEC: datapath evaluates latched operands; result and id registered at end of cycle; go to RESP.
REQ-020 RESP: rsp_valid=1; rsp_result/rsp_id stable while rsp_ready=0; on rsp_valid&rsp_ready go to IDLE.
REQ-021 Latency: grant in cycle N -> rsp_valid first high in cycle N+2; max throughput one operation per 3 cycles.
REQ-022 Requester operand changes after its grant cycle SHALL NOT affect the in-flight result.
REQ-023 Requester deasserting valid before grant: request withdrawn, no side effects.

Reset
REQ-024 Asserting reset at any time SHALL immediately force state IDLE, rsp_valid=0, req0_ready=req1_ready=0, rsp_result=0, rsp_id=0, priority pointer=requester 0.
REQ-025 An operation in flight at reset SHALL be discarded without response.
REQ-026 First grant possible in the first rising edge after reset deasserts.

Configuration
REQ-027 Macro ALU_ARBITER_FLAGS_EN defined: extra port rsp_flags  output  4  {N,Z,C,V} registered with rsp_result; N=result MSB, Z=result==0, C=adder carry-out, V=signed overflow of the selected operation; reset value 4'b0000.
REQ-028 Macro ALU_ARBITER_FLAGS_EN undefined: rsp_flags port and flag logic absent; all other behaviour identical.

Verification
REQ-029 Req0 only, a=5, b=3, op=0000, rsp_ready=1 -> req0_ready at cycle N, rsp_valid at N+2, rsp_result=8, rsp_id=0.
REQ-030 Req1 only, a=3, b=5, op=0010 -> rsp_result=32'hFFFF_FFFE, rsp_id=1; with FLAGS_EN flags N=1,Z=0,C=0,V=0.
REQ-031 Both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; one response per 3 cycles.
REQ-032 a=32'hFFFF_FFFF, b=1, ADD with rsp_ready=0 for 4 cycles -> rsp_result=0 held stable, no new grant until handshake; with FLAGS_EN Z=1,C=1,V=0.
REQ-033 Reset asserted during EXEC -> rsp_valid stays 0, no response for that op; next grant after reset goes to requester 0 when both valid.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one add/sub datapath through a
// round-robin arbiter. One operation is in flight at a time:
// grant (IDLE) -> compute (EXEC) -> hold response until accepted (RESP).
// Optional feature: define ALU_ARBITER_FLAGS_EN to add the rsp_flags output
// ({N,Z,C,V}, registered alongside rsp_result).

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_id
`ifdef ALU_ARBITER_FLAGS_EN
    ,
    output logic [3:0]       rsp_flags
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;       // requester that wins when both are valid
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_id;
    logic             w_grant;
    logic             w_grant_id;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;

    // Only op bit 1 selects the operation; the remaining bits are don't-care.
    logic w_unused_op_bits;
    assign w_unused_op_bits = ^{req0_op[3:2], req0_op[0], req1_op[3:2], req1_op[0]};

    // Arbitration and next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_id  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_grant    = 1'b1;
                    w_grant_id = r_prio;
                end else if (req0_valid) begin
                    w_grant    = 1'b1;
                    w_grant_id = 1'b0;
                end else if (req1_valid) begin
                    w_grant    = 1'b1;
                    w_grant_id = 1'b1;
                end else begin
                    w_grant    = 1'b0;
                    w_grant_id = 1'b0;
                end
                if (w_grant) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ready is a same-cycle acknowledge of the grant; suppressed while in reset
    assign req0_ready = w_grant & ~w_grant_id & ~reset;
    assign req1_ready = w_grant &  w_grant_id & ~reset;
    assign rsp_valid  = (r_state == ST_RESP);

    // State register and round-robin pointer (points away from the last winner)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_prio <= ~w_grant_id;
            end else begin
                r_prio <= r_prio;
            end
        end
    end

    // Capture the granted requester's operands so later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= {WIDTH{1'b0}};
            r_b   <= {WIDTH{1'b0}};
            r_sub <= 1'b0;
            r_id  <= 1'b0;
        end else if (w_grant) begin
            r_a   <= w_grant_id ? req1_a : req0_a;
            r_b   <= w_grant_id ? req1_b : req0_b;
            r_sub <= w_grant_id ? req1_op[1] : req0_op[1];
            r_id  <= w_grant_id;
        end
    end

    // Shared adder: subtract is a + ~b + 1, with the +1 entering as carry-in
    assign w_b_eff = r_sub ? ~r_b : r_b;
    assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_sub};

    // Response registers, loaded once at the end of EXEC and held through RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result <= {WIDTH{1'b0}};
            rsp_id     <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            rsp_result <= w_sum;
            rsp_id     <= r_id;
        end
    end

`ifdef ALU_ARBITER_FLAGS_EN
    logic w_ovf;
    // Signed overflow: both adder inputs share a sign that the sum does not
    assign w_ovf = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    // Flags register, loaded together with rsp_result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_flags <= 4'b0000;
        end else if (r_state == ST_EXEC) begin
            rsp_flags <= {w_sum[WIDTH-1], (w_sum == {WIDTH{1'b0}}), w_carry, w_ovf};
        end
    end
`else
    logic w_unused_carry;
    assign w_unused_carry = w_carry;
`endif

endmodule
